// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
// Priority states: fetch normally wins; the loader wins for one turn after a starvation run.
package imem_arb_pkg;

   localparam int DEFAULT_ADDR_W = 32;
   localparam int DEFAULT_DATA_W = 32;

   typedef enum logic [0:0] {
      FETCH_PRI = 1'b0,
      LDR_PRI   = 1'b1
   } arbState_e;

endpackage

// File: rtl/imem_arbiter.sv
// Two-requester arbiter sharing a single-port synchronous BRAM between CPU fetch and the loader.
// Fetch has fixed priority, bounded by a starvation counter that guarantees the loader a turn.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEFAULT_ADDR_W,
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int MAX_GRANT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req_valid,
   output logic              fetch_req_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_rsp_valid,
   output logic [DATA_W-1:0] fetch_rsp_data,
   input  logic              ldr_req_valid,
   output logic              ldr_req_ready,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_rsp_valid,
   output logic [DATA_W-1:0] ldr_rsp_data,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int              CNT_W   = $clog2(MAX_GRANT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANT);

   arbState_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rspFetch_q, rspFetch_d;
   logic             rspLdr_q, rspLdr_d;
   logic             fetchGrant, ldrGrant;

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      fetchGrant = 1'b0;
      ldrGrant   = 1'b0;
      if (!rst) begin
         case (state_q)
            LDR_PRI: begin
               ldrGrant   = ldr_req_valid;
               fetchGrant = fetch_req_valid & ~ldr_req_valid;
            end
            default: begin
               fetchGrant = fetch_req_valid;
               ldrGrant   = ldr_req_valid & ~fetch_req_valid;
            end
         endcase
      end
   end

   // Starvation tracking: the counter only runs while the loader is waiting behind fetch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ldrGrant || !ldr_req_valid) begin
         state_d = FETCH_PRI;
         cnt_d   = '0;
      end else if (fetchGrant && (state_q == FETCH_PRI)) begin
         if ((cnt_q + CNT_W'(1)) == CNT_MAX) begin
            state_d = LDR_PRI;
            cnt_d   = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      rspFetch_d = fetchGrant;
      rspLdr_d   = ldrGrant & ~ldr_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH_PRI;
         cnt_q      <= '0;
         rspFetch_q <= 1'b0;
         rspLdr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rspFetch_q <= rspFetch_d;
         rspLdr_q   <= rspLdr_d;
      end
   end

   // The BRAM port follows the winner in the same cycle; an idle port parks on the fetch address.
   always_comb begin
      mem_write_en   = 1'b0;
      mem_addr       = fetch_addr;
      mem_write_data = '0;
      if (ldrGrant) begin
         mem_write_en = ldr_we;
         mem_addr     = ldr_addr;
         if (ldr_we) begin
            mem_write_data = ldr_wdata;
         end
      end
   end

   assign fetch_req_ready = fetchGrant;
   assign ldr_req_ready   = ldrGrant;
   assign fetch_rsp_valid = rspFetch_q;
   assign ldr_rsp_valid   = rspLdr_q;
   assign fetch_rsp_data  = rspFetch_q ? mem_read_data : '0;
   assign ldr_rsp_data    = rspLdr_q ? mem_read_data : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a behavioural BRAM beside the DUT and a
// rule-level reference model predicting grants, BRAM port values and read responses.
module tb_imem_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_GRANT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fetch_req_valid = 1'b0;
   logic              fetch_req_ready;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic              fetch_rsp_valid;
   logic [DATA_W-1:0] fetch_rsp_data;
   logic              ldr_req_valid = 1'b0;
   logic              ldr_req_ready;
   logic              ldr_we = 1'b0;
   logic [ADDR_W-1:0] ldr_addr = '0;
   logic [DATA_W-1:0] ldr_wdata = '0;
   logic              ldr_rsp_valid;
   logic [DATA_W-1:0] ldr_rsp_data;
   logic              mem_write_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   int vectors;
   int miscompares;

   imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_GRANT(MAX_GRANT)) dut (
      .clk(clk), .rst(rst),
      .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
      .fetch_addr(fetch_addr), .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
      .ldr_req_valid(ldr_req_valid), .ldr_req_ready(ldr_req_ready), .ldr_we(ldr_we),
      .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rsp_valid(ldr_rsp_valid), .ldr_rsp_data(ldr_rsp_data),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Behavioural single-port BRAM: synchronous write, registered read, 16 words.
   logic [DATA_W-1:0] bram [16];
   always @(posedge clk) begin
      if (mem_write_en) bram[mem_addr[3:0]] <= mem_write_data;
      mem_read_data <= bram[mem_addr[3:0]];
   end

   // Reference model: the loader wins when it is valid and either fetch is idle or it
   // has already watched MAX_GRANT fetch grants go by since its last turn.
   logic [DATA_W-1:0] refMem [16];
   int                waitCnt;
   logic              gF, gL;
   logic              expFV, expLV;
   logic [DATA_W-1:0] expFD, expLD;

   function automatic void predict();
      logic lWins;
      lWins = ldr_req_valid && (!fetch_req_valid || waitCnt >= MAX_GRANT);
      gL = lWins;
      gF = fetch_req_valid && !lWins;
   endfunction

   // Drive one cycle's requests at the falling edge and let the combinational outputs settle.
   task automatic applyStimulus(input logic fv, input logic [ADDR_W-1:0] fa, input logic lv,
                                input logic lwe, input logic [ADDR_W-1:0] la,
                                input logic [DATA_W-1:0] ld);
      fetch_req_valid = fv;
      fetch_addr      = fa;
      ldr_req_valid   = lv;
      ldr_we          = lwe;
      ldr_addr        = la;
      ldr_wdata       = ld;
      #1;
      predict();
   endtask

   // Cross the rising edge and move the model forward by the grants it predicted.
   task automatic advance();
      logic              sgF = gF;
      logic              sgL = gL;
      logic              sWe = ldr_we;
      logic              sLv = ldr_req_valid;
      logic [3:0]        sFa = fetch_addr[3:0];
      logic [3:0]        sLa = ldr_addr[3:0];
      logic [DATA_W-1:0] sLd = ldr_wdata;
      @(posedge clk);
      if (sgL && sWe) refMem[sLa] = sLd;
      expFV = sgF;
      expFD = sgF ? refMem[sFa] : '0;
      expLV = sgL && !sWe;
      expLD = expLV ? refMem[sLa] : '0;
      if (sgL || !sLv) waitCnt = 0;
      else if (sgF) waitCnt++;
      @(negedge clk);
   endtask

   task automatic resetModel();
      waitCnt = 0;
      expFV = 1'b0;
      expLV = 1'b0;
      expFD = '0;
      expLD = '0;
   endtask

   // Requests are raised during reset; nothing may be granted or reported.
   task automatic test_reset();
      rst = 1'b1;
      fetch_req_valid = 1'b1;
      ldr_req_valid = 1'b1;
      ldr_we = 1'b1;
      @(negedge clk);
      #1;
      vectors++; if (fetch_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_fetch_ready: got %b expected 0", fetch_req_ready); end
      vectors++; if (ldr_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ldr_ready: got %b expected 0", ldr_req_ready); end
      vectors++; if (fetch_rsp_valid !== 1'b0 || ldr_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rsp_valid: got %b%b expected 00", fetch_rsp_valid, ldr_rsp_valid); end
      vectors++; if (fetch_rsp_data !== '0 || ldr_rsp_data !== '0) begin miscompares++; $display("[TB] FAIL rst_rsp_data: got %h/%h expected 0/0", fetch_rsp_data, ldr_rsp_data); end
      vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_write_en: got %b expected 0", mem_write_en); end
      fetch_req_valid = 1'b0;
      ldr_req_valid = 1'b0;
      ldr_we = 1'b0;
      rst = 1'b0;
      resetModel();
      @(negedge clk);
   endtask

   // Fetch alone streams addresses 0,1,2; responses follow one cycle behind each grant.
   task automatic test_fetch_stream();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i < 3, ADDR_W'(i), 1'b0, 1'b0, '0, '0);
         vectors++; if (fetch_req_ready !== (i < 3)) begin miscompares++; $display("[TB] FAIL fs_ready[%0d]: got %b expected %b", i, fetch_req_ready, i < 3); end
         vectors++; if (mem_addr !== ADDR_W'(i)) begin miscompares++; $display("[TB] FAIL fs_addr[%0d]: got %h expected %h", i, mem_addr, i); end
         vectors++; if (fetch_rsp_valid !== expFV || fetch_rsp_data !== expFD) begin miscompares++; $display("[TB] FAIL fs_rsp[%0d]: got %b/%h expected %b/%h", i, fetch_rsp_valid, fetch_rsp_data, expFV, expFD); end
         advance();
      end
   endtask

   task automatic test_write_then_read();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, ADDR_W'(4), 32'hDEADBEEF);
      vectors++; if (ldr_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ready: got %b expected 1", ldr_req_ready); end
      vectors++; if (mem_write_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_en: got %b expected 1", mem_write_en); end
      vectors++; if (mem_addr !== ADDR_W'(4) || mem_write_data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL wr_port: got %h/%h expected 4/deadbeef", mem_addr, mem_write_data); end
      advance();
      applyStimulus(1'b1, ADDR_W'(4), 1'b0, 1'b0, '0, '0);
      vectors++; if (fetch_req_ready !== 1'b1 || mem_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rd4_grant: got ready %b we %b expected 1/0", fetch_req_ready, mem_write_en); end
      vectors++; if (ldr_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_no_rsp: got %b expected 0", ldr_rsp_valid); end
      advance();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      vectors++; if (fetch_rsp_valid !== 1'b1 || fetch_rsp_data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL rd4_data: got %b/%h expected 1/deadbeef", fetch_rsp_valid, fetch_rsp_data); end
      advance();
   endtask

   // Both requesters saturated: grants must follow F,F,F,F,L.
   task automatic test_fairness();
      int gap = 0;
      int maxGap = 0;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, ADDR_W'(i % 16), 1'b1, 1'b0, ADDR_W'(2), '0);
         vectors++; if (ldr_req_ready !== ((i % 5) == 4) || fetch_req_ready !== ((i % 5) != 4)) begin miscompares++; $display("[TB] FAIL fair_grant[%0d]: got F%b L%b expected L=%b", i, fetch_req_ready, ldr_req_ready, (i % 5) == 4); end
         vectors++; if (fetch_rsp_valid !== expFV || ldr_rsp_valid !== expLV || fetch_rsp_data !== expFD || ldr_rsp_data !== expLD) begin miscompares++; $display("[TB] FAIL fair_rsp[%0d]: got %b%b %h/%h expected %b%b %h/%h", i, fetch_rsp_valid, ldr_rsp_valid, fetch_rsp_data, ldr_rsp_data, expFV, expLV, expFD, expLD); end
         gap++;
         if (ldr_req_ready === 1'b1) begin
            if (gap > maxGap) maxGap = gap;
            gap = 0;
         end
         advance();
      end
      vectors++; if (maxGap > MAX_GRANT + 1 || maxGap == 0) begin miscompares++; $display("[TB] FAIL fair_gap: got %0d expected 1..%0d", maxGap, MAX_GRANT + 1); end
   endtask

   task automatic test_ldr_read();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, ADDR_W'(1), '0);
      vectors++; if (ldr_req_ready !== 1'b1 || mem_addr !== ADDR_W'(1) || mem_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL lr_grant: got %b/%h/%b expected 1/1/0", ldr_req_ready, mem_addr, mem_write_en); end
      advance();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      vectors++; if (ldr_rsp_valid !== 1'b1 || ldr_rsp_data !== 32'h00100093) begin miscompares++; $display("[TB] FAIL lr_rsp: got %b/%h expected 1/00100093", ldr_rsp_valid, ldr_rsp_data); end
      vectors++; if (fetch_rsp_valid !== 1'b0 || fetch_rsp_data !== '0) begin miscompares++; $display("[TB] FAIL lr_fetch_quiet: got %b/%h expected 0/0", fetch_rsp_valid, fetch_rsp_data); end
      advance();
   endtask

   // Loader waits through 3 fetch grants, drops for a cycle, then must wait 4 more.
   task automatic test_counter_restart();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, ADDR_W'(i), i != 3, 1'b0, ADDR_W'(0), '0);
         vectors++; if (ldr_req_ready !== (i == 8) || fetch_req_ready !== (i != 8)) begin miscompares++; $display("[TB] FAIL restart[%0d]: got F%b L%b expected L=%b", i, fetch_req_ready, ldr_req_ready, i == 8); end
         advance();
      end
   endtask

   // Loader drops exactly when it has earned priority: no spurious write, fetch keeps going.
   task automatic test_ldr_drop();
      logic [DATA_W-1:0] d = DATA_W'($urandom);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, ADDR_W'(i), i != 4, 1'b1, ADDR_W'(5), d);
         vectors++; if (ldr_req_ready !== (i == 9) || fetch_req_ready !== (i != 9)) begin miscompares++; $display("[TB] FAIL drop[%0d]: got F%b L%b expected L=%b", i, fetch_req_ready, ldr_req_ready, i == 9); end
         vectors++; if (mem_write_en !== (i == 9)) begin miscompares++; $display("[TB] FAIL drop_we[%0d]: got %b expected %b", i, mem_write_en, i == 9); end
         advance();
      end
   endtask

   // Random traffic under the hold-until-ready protocol, checked against the model.
   task automatic test_random();
      logic              fPend = 1'b0, lPend = 1'b0, lWe = 1'b0;
      logic [ADDR_W-1:0] fA = '0, lA = '0;
      logic [DATA_W-1:0] lD = '0;
      int                lWait = 0;
      for (int i = 0; i < 400; i++) begin
         if (!fPend && $urandom_range(99) < 70) begin
            fPend = 1'b1;
            fA = ADDR_W'($urandom_range(15));
         end
         if (!lPend && $urandom_range(99) < 50) begin
            lPend = 1'b1;
            lWe = 1'($urandom_range(1));
            lA = ADDR_W'($urandom_range(15));
            lD = DATA_W'($urandom);
            lWait = 0;
         end
         applyStimulus(fPend, fA, lPend, lWe, lA, lD);
         vectors++; if (fetch_req_ready !== gF || ldr_req_ready !== gL) begin miscompares++; $display("[TB] FAIL rnd_grant[%0d]: got F%b L%b expected F%b L%b", i, fetch_req_ready, ldr_req_ready, gF, gL); end
         vectors++; if (mem_write_en !== (gL && lWe) || mem_addr !== (gL ? lA : fA)) begin miscompares++; $display("[TB] FAIL rnd_port[%0d]: got %b/%h expected %b/%h", i, mem_write_en, mem_addr, gL && lWe, gL ? lA : fA); end
         if (!gL || lWe) begin
            vectors++; if (mem_write_data !== ((gL && lWe) ? lD : '0)) begin miscompares++; $display("[TB] FAIL rnd_wdata[%0d]: got %h expected %h", i, mem_write_data, (gL && lWe) ? lD : '0); end
         end
         vectors++; if (fetch_rsp_valid !== expFV || fetch_rsp_data !== expFD) begin miscompares++; $display("[TB] FAIL rnd_frsp[%0d]: got %b/%h expected %b/%h", i, fetch_rsp_valid, fetch_rsp_data, expFV, expFD); end
         vectors++; if (ldr_rsp_valid !== expLV || ldr_rsp_data !== expLD) begin miscompares++; $display("[TB] FAIL rnd_lrsp[%0d]: got %b/%h expected %b/%h", i, ldr_rsp_valid, ldr_rsp_data, expLV, expLD); end
         if (lPend) lWait++;
         if (gL) begin
            vectors++; if (lWait > MAX_GRANT + 1) begin miscompares++; $display("[TB] FAIL rnd_starve[%0d]: got %0d cycles expected <= %0d", i, lWait, MAX_GRANT + 1); end
            lPend = 1'b0;
         end
         if (gF) fPend = 1'b0;
         advance();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      advance();
   endtask

   // Reset lands just after a fetch read grant that also pushed the FSM toward loader priority.
   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, ADDR_W'(i), 1'b1, 1'b0, ADDR_W'(3), '0);
         if (i < 3) advance();
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (fetch_rsp_valid !== 1'b0 || fetch_rsp_data !== '0) begin miscompares++; $display("[TB] FAIL ar_rsp_kill: got %b/%h expected 0/0", fetch_rsp_valid, fetch_rsp_data); end
      vectors++; if (fetch_req_ready !== 1'b0 || ldr_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_ready: got F%b L%b expected 00", fetch_req_ready, ldr_req_ready); end
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      applyStimulus(1'b1, ADDR_W'(7), 1'b1, 1'b0, ADDR_W'(3), '0);
      vectors++; if (fetch_req_ready !== 1'b1 || ldr_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_first_grant: got F%b L%b expected F1 L0", fetch_req_ready, ldr_req_ready); end
      vectors++; if (fetch_rsp_valid !== 1'b0 || ldr_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_no_rsp: got %b%b expected 00", fetch_rsp_valid, ldr_rsp_valid); end
      advance();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      vectors++; if (fetch_rsp_valid !== expFV || fetch_rsp_data !== expFD) begin miscompares++; $display("[TB] FAIL ar_post_rsp: got %b/%h expected %b/%h", fetch_rsp_valid, fetch_rsp_data, expFV, expFD); end
      advance();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      resetModel();
      for (int i = 0; i < 16; i++) begin
         refMem[i] = DATA_W'($urandom);
      end
      refMem[0] = 32'h00000013;
      refMem[1] = 32'h00100093;
      refMem[2] = 32'h00200113;
      for (int i = 0; i < 16; i++) begin
         bram[i] = refMem[i];
      end
      $display("[TB] imem_arbiter bench start, MAX_GRANT=%0d", MAX_GRANT);
      test_reset();
      test_fetch_stream();
      test_write_then_read();
      test_fairness();
      test_ldr_read();
      test_counter_restart();
      test_ldr_drop();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter in front of the single-port instruction BRAM (synchronous read, 1-cycle latency, synchronous write). It shares the BRAM between the CPU fetch unit (read-only) and the program loader/debug port (read/write). Fetch has fixed priority, bounded by a starvation counter that guarantees the loader a grant. It sits between the fetch stage, the loader, and the BRAM's clk/write_en/addr/write_data/read_data port.

## Interface
- ADDR_W, 32, word address width (BRAM index, not byte address)
- DATA_W, 32, data width
- MAX_GRANT, 4, consecutive fetch grants allowed while loader waits (≥1)

- clk  in  1  rising-edge clock shared with BRAM
- rst  in  1  asynchronous, active-high reset
- fetch_req_valid  in  1  fetch read request
- fetch_req_ready  out  1  fetch request accepted this cycle
- fetch_addr  in  ADDR_W  fetch word address
- fetch_rsp_valid  out  1  fetch read data valid
- fetch_rsp_data  out  DATA_W  fetch read data
- ldr_req_valid  in  1  loader request
- ldr_req_ready  out  1  loader request accepted this cycle
- ldr_we  in  1  1 = write, 0 = read
- ldr_addr  in  ADDR_W  loader word address
- ldr_wdata  in  DATA_W  loader write data
- ldr_rsp_valid  out  1  loader read data valid (reads only)
- ldr_rsp_data  out  DATA_W  loader read data
- mem_write_en  out  1  to BRAM write_en
- mem_addr  out  ADDR_W  to BRAM addr
- mem_write_data  out  DATA_W  to BRAM write_data
- mem_read_data  in  DATA_W  from BRAM read_data

## Operation
- At most one request granted per cycle. A request transfers when valid and ready are both high.
- Requesters hold valid, address and data stable until ready. Ready is combinational from valid and state; valid never depends on ready.
- Granted request drives the mem_* outputs combinationally in the same cycle.
- No grant: mem_write_en=0, mem_addr=fetch_addr, mem_write_data=0.
- FSM, 2 states:
  - FETCH_PRI (reset state): fetch wins if valid, otherwise loader wins.
    - Counter increments on each fetch grant while ldr_req_valid=1.
    - When a fetch grant makes the counter reach MAX_GRANT, next state is LDR_PRI.
  - LDR_PRI: loader wins if valid, otherwise fetch wins.
    - Return to FETCH_PRI on the loader grant, or on any cycle with ldr_req_valid=0.
- Counter clears to 0 on: any loader grant, any cycle with ldr_req_valid=0, and entry into LDR_PRI. Width is clog2(MAX_GRANT+1); it never wraps.
- Read response:
  - Registered flag rsp_owner_fetch / rsp_owner_ldr is set on the edge that accepts a read.
  - In the following cycle, that requester's rsp_valid=1 and its rsp_data=mem_read_data. The other requester's rsp_data=0.
- Writes (ldr_we=1) produce no response.
- Back-to-back reads from either or both requesters are allowed, one per cycle. Responses return in grant order, one cycle after each grant.

## Timing
- Reset values: fetch_req_ready=0, ldr_req_ready=0 (while rst high), fetch_rsp_valid=0, ldr_rsp_valid=0, both rsp_data=0, mem_write_en=0, state=FETCH_PRI, counter=0.
- Read latency: grant at edge N, data valid in cycle N+1 (between edges N and N+1).
- Write: committed at the granting edge. A read of the same address granted on the next edge returns the new data.
- Fairness bound: a continuously valid loader is granted within MAX_GRANT+1 cycles under continuous fetch traffic.
- Simultaneous valid in FETCH_PRI with counter<MAX_GRANT: fetch granted, loader stalls, counter increments.
- Reset asserted with a read in flight: rsp_valid is forced 0 immediately and the response is discarded. Post-reset arbitration starts in FETCH_PRI.
- ldr_req_valid dropping while in LDR_PRI (protocol violation tolerated): FSM returns to FETCH_PRI and no spurious grant is made.

## Structure
- Package imem_arb_pkg holds the state enum (FETCH_PRI, LDR_PRI) and the default ADDR_W/DATA_W constants.
- No sub-module. The counter and FSM stay inline. The BRAM is instantiated beside the arbiter at the level above.

## Test plan
- BRAM preloaded mem[0..2]=0x00000013, 0x00100093, 0x00200113. Fetch alone issues addr 0,1,2 on consecutive cycles -> fetch_req_ready=1 each cycle; fetch_rsp_valid=1 one cycle after each grant with the preloaded words in order.
- Loader writes 0xDEADBEEF to addr 4, then a fetch reads addr 4 on the next cycle -> mem_write_en pulses once and fetch_rsp_data=0xDEADBEEF.
- Fetch and loader both continuously valid, MAX_GRANT=4 -> grant pattern F,F,F,F,L repeats. The loader is never starved beyond 5 cycles.
- Loader read of addr 1 concurrent with fetch idle -> ldr_rsp_valid=1 next cycle with 0x00100093, and fetch_rsp_valid stays 0.
- Loader valid for 3 fetch grants, then drops, then re-asserts -> counter restarts from 0. The loader is granted after 4 further fetch grants, not 1.
- rst asserted asynchronously mid-cycle right after a fetch read grant -> fetch_rsp_valid=0 immediately and no response after reset; the first post-reset grant goes to fetch.
